// File: rtl/bilbo_reg_bist.sv
// bilbo_reg_bist: BILBO register with built-in self-test session controller
module bilbo_reg_bist #(
    parameter int                WIDTH  = 8,
    parameter logic [WIDTH-1:0]  POLY   = 8'hB8,
    parameter logic [WIDTH-1:0]  SEED   = 8'h01,
    parameter int                NPAT   = 255,
    parameter logic [WIDTH-1:0]  GOLDEN = 8'h00
) (
    input  logic             clock,
    input  logic             rst_l,
    input  logic [1:0]       mode,
    input  logic             prpg,
    input  logic [WIDTH-1:0] data,
    input  logic             scan_in,
    input  logic             start,
    output logic [WIDTH-1:0] q,
    output logic             scan_out,
    output logic             busy,
    output logic             done,
    output logic             pass
);
    localparam int             CW       = $clog2(NPAT + 1);
    localparam logic [CW-1:0]  LAST     = CW'(NPAT - 1);
    localparam logic [1:0]     M_SHIFT  = 2'b00;
    localparam logic [1:0]     M_CLEAR  = 2'b01;
    localparam logic [1:0]     M_LFSR   = 2'b10;
    localparam logic [1:0]     M_NORMAL = 2'b11;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] q_q, q_d, lfsr, op;
    logic             busy_q, done_q, pass_q, start_ok;

    // Register next state: session start wins, then frozen signature, then the selected mode
    always_comb begin
        lfsr     = {q_q[WIDTH-2:0], ^(q_q & POLY)};
        op       = (mode == M_NORMAL) ? data :
                   (mode == M_SHIFT)  ? {q_q[WIDTH-2:0], scan_in} :
                   (mode == M_CLEAR)  ? '0 :
                   prpg               ? lfsr : lfsr ^ data;
        start_ok = start && (state_q != RUN);
        q_d      = start_ok                                ? SEED :
                   (state_q == DONE && mode == M_LFSR)     ? q_q  : op;
    end

    // Register, cycle counter and session FSM with registered status flags
    always_ff @(posedge clock) begin
        if (!rst_l) begin
            q_q     <= '0;
            state_q <= IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            pass_q  <= 1'b0;
        end else begin
            q_q <= q_d;
            case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        state_q <= RUN;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end
                end
                RUN: begin
                    if (mode != M_LFSR) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                    end else if (cnt_q == LAST) begin
                        state_q <= DONE;
                        cnt_q   <= '0;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        pass_q  <= (q_d == GOLDEN);
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    pass_q  <= 1'b0;
                end
            endcase
        end
    end

    assign q        = q_q;
    assign scan_out = q_q[WIDTH-1];
    assign busy     = busy_q;
    assign done     = done_q;
    assign pass     = pass_q;
endmodule

// File: tb/tb_bilbo_reg_bist.sv
// tb_bilbo_reg_bist: directed scoreboard bench for two BILBO instances differing only in GOLDEN
module tb_bilbo_reg_bist;
    logic       clock = 1'b0;
    logic       rst_l = 1'b0;
    logic [1:0] mode = 2'b11;
    logic       prpg = 1'b0;
    logic [3:0] data = 4'h0;
    logic       scan_in = 1'b0;
    logic       start = 1'b0;

    logic [3:0] qa, qb;
    logic       soa, sob, ba, bb, da, db, pa, pb;

    typedef struct packed {
        logic [3:0] q;
        logic       so;
        logic       b;
        logic       d;
        logic       pa;
        logic       pb;
    } exp_t;

    exp_t sb[$];
    int   vectors = 0;
    int   miscompares = 0;

    logic [3:0] seq [15] = '{4'h3, 4'h7, 4'hF, 4'hE, 4'hD, 4'hA, 4'h5, 4'hB,
                             4'h6, 4'hC, 4'h9, 4'h2, 4'h4, 4'h8, 4'h1};

    always #5 clock = ~clock;

    bilbo_reg_bist #(.WIDTH(4), .POLY(4'h9), .SEED(4'h1), .NPAT(15), .GOLDEN(4'h1)) dut_a (
        .clock(clock), .rst_l(rst_l), .mode(mode), .prpg(prpg), .data(data),
        .scan_in(scan_in), .start(start), .q(qa), .scan_out(soa),
        .busy(ba), .done(da), .pass(pa)
    );

    bilbo_reg_bist #(.WIDTH(4), .POLY(4'h9), .SEED(4'h1), .NPAT(15), .GOLDEN(4'h2)) dut_b (
        .clock(clock), .rst_l(rst_l), .mode(mode), .prpg(prpg), .data(data),
        .scan_in(scan_in), .start(start), .q(qb), .scan_out(sob),
        .busy(bb), .done(db), .pass(pb)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input logic r, input logic s, input logic [1:0] m, input logic p,
                       input logic [3:0] d, input logic si, input logic [3:0] eq,
                       input logic eb, input logic ed, input logic epa, input logic epb,
                       input logic eso);
        exp_t e;
        sb.push_back('{q: eq, so: eso, b: eb, d: ed, pa: epa, pb: epb});
        rst_l = r; start = s; mode = m; prpg = p; data = d; scan_in = si;
        @(posedge clock);
        #1;
        e = sb.pop_front();
        chk("q_a", qa, e.q);
        chk("q_b", qb, e.q);
        chk("scan_out", {3'b0, soa}, {3'b0, e.so});
        chk("busy_a", {3'b0, ba}, {3'b0, e.b});
        chk("busy_b", {3'b0, bb}, {3'b0, e.b});
        chk("done_a", {3'b0, da}, {3'b0, e.d});
        chk("done_b", {3'b0, db}, {3'b0, e.d});
        chk("pass_a", {3'b0, pa}, {3'b0, e.pa});
        chk("pass_b", {3'b0, pb}, {3'b0, e.pb});
    endtask

    initial begin
        // reset then normal capture
        cyc(0, 0, 2'b11, 0, 4'hF, 0, 4'h0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b11, 0, 4'hF, 0, 4'hF, 0, 0, 0, 0, 1);
        // clear then scan 1,0,1,1
        cyc(1, 0, 2'b01, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b00, 0, 4'h0, 1, 4'h1, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b00, 0, 4'h0, 0, 4'h2, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b00, 0, 4'h0, 1, 4'h5, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b00, 0, 4'h0, 1, 4'hB, 0, 0, 0, 0, 1);
        // full PRPG session: 15 advances back to seed, terminal edge flags done
        cyc(1, 1, 2'b11, 0, 4'h7, 0, 4'h1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++)
            cyc(1, 0, 2'b10, 1, 4'h0, 0, seq[i], i < 14, i == 14, i == 14, 0, seq[i][3]);
        // signature frozen in DONE under mode 10, then scannable with flags held
        cyc(1, 0, 2'b10, 1, 4'h0, 0, 4'h1, 0, 1, 1, 0, 0);
        cyc(1, 0, 2'b10, 0, 4'h6, 0, 4'h1, 0, 1, 1, 0, 0);
        cyc(1, 0, 2'b00, 0, 4'h0, 0, 4'h2, 0, 1, 1, 0, 0);
        // reset from DONE, then free-running MISR outside a session
        cyc(0, 0, 2'b10, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b11, 0, 4'h1, 0, 4'h1, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b10, 0, 4'h1, 0, 4'h2, 0, 0, 0, 0, 0);
        // all-zero state locks the pure LFSR
        cyc(1, 0, 2'b01, 0, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b10, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b10, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        // abort after 5 cycles by leaving mode 10
        cyc(1, 1, 2'b10, 1, 4'h0, 0, 4'h1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++)
            cyc(1, 0, 2'b10, 1, 4'h0, 0, seq[i], 1, 0, 0, 0, seq[i][3]);
        cyc(1, 0, 2'b11, 0, 4'hA, 0, 4'hA, 0, 0, 0, 0, 1);
        // restart re-seeds with a fresh count; start at RUN cycle 3 is ignored
        cyc(1, 1, 2'b11, 0, 4'h3, 0, 4'h1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 15; i++)
            cyc(1, i == 2, 2'b10, 1, 4'h0, 0, seq[i], i < 14, i == 14, i == 14, 0, seq[i][3]);
        // restart from DONE, reset at RUN cycle 7 aborts with no residue
        cyc(1, 1, 2'b10, 1, 4'h0, 0, 4'h1, 1, 0, 0, 0, 0);
        for (int i = 0; i < 6; i++)
            cyc(1, 0, 2'b10, 1, 4'h0, 0, seq[i], 1, 0, 0, 0, seq[i][3]);
        cyc(0, 0, 2'b10, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        cyc(1, 0, 2'b10, 1, 4'h0, 0, 4'h0, 0, 0, 0, 0, 0);
        cyc(1, 1, 2'b10, 1, 4'h0, 0, 4'h1, 1, 0, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
